// File: rtl/tinymips_ctrl_pkg.sv
// Shared encodings for the TinyMIPS multicycle controller: opcodes, state codes,
// datapath select encodings and the bundled control-output record.
package tinymips_ctrl_pkg;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // FETCH1..FETCH4 occupy 0..3 so state[1:0] doubles as the IR byte index.
  localparam logic [3:0] StFetch1  = 4'd0;
  localparam logic [3:0] StFetch2  = 4'd1;
  localparam logic [3:0] StFetch3  = 4'd2;
  localparam logic [3:0] StFetch4  = 4'd3;
  localparam logic [3:0] StDecode  = 4'd4;
  localparam logic [3:0] StMemAdr  = 4'd5;
  localparam logic [3:0] StLbRd    = 4'd6;
  localparam logic [3:0] StLbWr    = 4'd7;
  localparam logic [3:0] StSbWr    = 4'd8;
  localparam logic [3:0] StRtypeEx = 4'd9;
  localparam logic [3:0] StRtypeWr = 4'd10;
  localparam logic [3:0] StBeqEx   = 4'd11;
  localparam logic [3:0] StJEx     = 4'd12;
  localparam logic [3:0] StAddiEx  = 4'd13;
  localparam logic [3:0] StAddiWr  = 4'd14;
  localparam logic [3:0] StTrap    = 4'd15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       mdr_en;
    logic       pcen;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

  function automatic logic [3:0] decode_next(input logic [5:0] op);
    logic [3:0] nxt;
    unique case (op)
      OP_LB, OP_SB: nxt = StMemAdr;
      OP_RTYPE:     nxt = StRtypeEx;
      OP_BEQ:       nxt = StBeqEx;
      OP_J:         nxt = StJEx;
      OP_ADDI:      nxt = StAddiEx;
      default:      nxt = StTrap;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder for the multicycle controller; memory strobes are
// qualified by rdy and the branch PC enable by the ALU zero flag.
module mc_ctrl_outdec
  import tinymips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       rdy,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch1, StFetch2, StFetch3, StFetch4: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_ONE;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        if (rdy) begin
          ctrl.irwrite = 4'b0001 << state[1:0];
          ctrl.pcen    = 1'b1;
        end
      end
      StDecode: begin
        ctrl.alusrcb = SRCB_BRIMM;
      end
      StMemAdr: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      StLbRd: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.mdr_en  = rdy;
      end
      StLbWr: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StSbWr: begin
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = rdy;
      end
      StRtypeEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      StRtypeWr: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StBeqEx: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsource   = PCSRC_ALUOUT;
        ctrl.pcen       = zero;
        ctrl.instr_done = 1'b1;
      end
      StJEx: begin
        ctrl.pcsource   = PCSRC_JUMP;
        ctrl.pcen       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StAddiEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      StAddiWr: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StTrap: begin
        ctrl.trap = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// TinyMIPS multicycle control sequencer: state register and next-state logic,
// with output decode delegated to mc_ctrl_outdec.
module mc_control_fsm
  import tinymips_ctrl_pkg::*;
#(
  parameter bit MEM_HS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       mdr_en,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       instr_done,
  output logic       trap
);

  logic [3:0] state_q, state_d;
  logic       rdy;
  ctrl_t      ctrl;

  // Without the handshake every access completes in a single cycle.
  assign rdy = MEM_HS ? mem_rdy : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch1:  if (rdy) state_d = StFetch2;
      StFetch2:  if (rdy) state_d = StFetch3;
      StFetch3:  if (rdy) state_d = StFetch4;
      StFetch4:  if (rdy) state_d = StDecode;
      StDecode:  state_d = decode_next(op);
      StMemAdr:  state_d = (op == OP_SB) ? StSbWr : StLbRd;
      StLbRd:    if (rdy) state_d = StLbWr;
      StLbWr:    state_d = StFetch1;
      StSbWr:    if (rdy) state_d = StFetch1;
      StRtypeEx: state_d = StRtypeWr;
      StRtypeWr: state_d = StFetch1;
      StBeqEx:   state_d = StFetch1;
      StJEx:     state_d = StFetch1;
      StAddiEx:  state_d = StAddiWr;
      StAddiWr:  state_d = StFetch1;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch1;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .rdy   (rdy),
    .zero  (zero),
    .ctrl  (ctrl)
  );

  assign memread    = ctrl.memread;
  assign memwrite   = ctrl.memwrite;
  assign iord       = ctrl.iord;
  assign irwrite    = ctrl.irwrite;
  assign mdr_en     = ctrl.mdr_en;
  assign pcen       = ctrl.pcen;
  assign pcsource   = ctrl.pcsource;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign regwrite   = ctrl.regwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign instr_done = ctrl.instr_done;
  assign trap       = ctrl.trap;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control sequencer for the 8-bit TinyMIPS datapath.
- Steps the datapath through byte-wise instruction fetch, decode, execute, memory and writeback.
- Drives the enable inputs of the datapath's enable-gated registers (IR bytes, PC, MDR) and the mux/ALU selects.
- Stalls on a memory ready handshake and traps on illegal opcodes.

Parameters:
- MEM_HS, 1: 1 = memory states wait for mem_rdy; 0 = mem_rdy is treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- op  in  6  opcode field from IR.
- zero  in  1  ALU zero flag.
- mem_rdy  in  1  memory completes the current access this cycle.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- iord  out  1  address mux: 0 = PC, 1 = ALUOut.
- irwrite  out  4  one-hot IR byte enable.
- mdr_en  out  1  MDR load enable.
- pcen  out  1  PC load enable.
- pcsource  out  2  PC mux: 00 = ALU, 01 = ALUOut, 10 = jump.
- alusrca  out  1  ALU A mux: 0 = PC, 1 = regA.
- alusrcb  out  2  ALU B mux: 00 = regB, 01 = const 1, 10 = imm, 11 = imm (branch).
- aluop  out  2  00 = add, 01 = sub, 10 = funct.
- regwrite  out  1  register file write enable.
- regdst  out  1  write register: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- trap  out  1  illegal opcode seen; sticky.

Behaviour:
- States: FETCH1..FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR, TRAP. State register is 4 bits.
- Reset: rst=0 forces state FETCH1 immediately; aborts any instruction mid-flight.
- Outputs are Moore decode of state, with strobes qualified by mem_rdy as noted. Any output not listed for a state is 0.
- Outputs during reset (FETCH1):
  - memread=1, alusrcb=01.
  - irwrite=0001 and pcen=1 only if mem_rdy=1.
  - All others 0, including trap=0 and instr_done=0.
- FETCHn (n=1..4):
  - memread=1, alusrcb=01, aluop=00, pcsource=00.
  - When mem_rdy=1: irwrite bit n-1 set, pcen=1, advance to FETCHn+1 (FETCH4 -> DECODE).
  - When mem_rdy=0: hold state, irwrite=0, pcen=0.
- DECODE: alusrcb=11. Next state by op:
  - 100000 (lb) and 101000 (sb) -> MEMADR.
  - 000000 -> RTYPEEX.
  - 000100 -> BEQEX.
  - 000010 -> JEX.
  - 001000 -> ADDIEX.
  - Any other op -> TRAP.
- MEMADR: alusrca=1, alusrcb=10. Next LBRD for lb, SBWR for sb.
- LBRD: memread=1, iord=1; mdr_en=mem_rdy; hold until mem_rdy, then LBWR.
- LBWR: regwrite=1, memtoreg=1, instr_done=1 -> FETCH1.
- SBWR: memwrite=1, iord=1; hold until mem_rdy; instr_done=mem_rdy; -> FETCH1.
- RTYPEEX: alusrca=1, aluop=10 -> RTYPEWR.
- RTYPEWR: regdst=1, regwrite=1, instr_done=1 -> FETCH1.
- BEQEX: alusrca=1, aluop=01, pcsource=01, pcen=zero, instr_done=1 -> FETCH1.
- JEX: pcsource=10, pcen=1, instr_done=1 -> FETCH1.
- ADDIEX: alusrca=1, alusrcb=10 -> ADDIWR.
- ADDIWR: regwrite=1, regdst=0, instr_done=1 -> FETCH1.
- TRAP: trap=1; all strobes 0; self-loop until reset.
- Latency with mem_rdy held at 1: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6 cycles.
- Invariants:
  - memread and memwrite are never both 1.
  - irwrite is one-hot or zero.
  - An undefined state encoding recovers to FETCH1 on the next clock.

Decomposition:
- Package tinymips_ctrl_pkg holds:
  - opcode constants OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI;
  - the state enum/localparams;
  - encodings for aluop, alusrcb and pcsource.
- One natural sub-module, mc_ctrl_outdec: purely combinational state + mem_rdy + zero -> outputs decoder.
- The top level keeps the state register and next-state logic.

Test Plan:
- Reset held low, mem_rdy=1: state FETCH1, memread=1, irwrite=0001, pcen=1, trap=0. Release reset: irwrite sequences 0001, 0010, 0100, 1000 on consecutive cycles.
- op=000000, mem_rdy=1 -> exactly one regwrite cycle with regdst=1, in cycle 7 after FETCH1 entry; instr_done in the same cycle; back to FETCH1.
- op=100000, mem_rdy low for 3 cycles during LBRD:
  - memread and iord held for all 4 LBRD cycles;
  - mdr_en=1 only in the last LBRD cycle;
  - then LBWR with memtoreg=1 and regwrite=1;
  - total 11 cycles.
- op=000100 with zero=1 -> pcen=1 and pcsource=01 in BEQEX. Repeat with zero=0 -> pcen=0, still returns to FETCH1 after 6 cycles.
- op=111111 -> TRAP after DECODE:
  - trap=1 and all strobes 0 for 20 cycles;
  - rst pulsed low mid-TRAP -> FETCH1, trap=0.
- rst asserted asynchronously mid-SBWR while memwrite=1 -> memwrite drops before the next clock edge, state FETCH1, no instr_done pulse.
